// File: rtl/letc_core_pkg.sv
// Shared LETC core types: memory2-to-writeback bundle, AMO ops and writeback AMO FSM states.
package letc_core_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned RIDX_W    = 5;
  localparam int unsigned CSR_IDX_W = 12;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t BAD_WORD = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    RD_SRC_ALU = 2'd0,
    RD_SRC_CSR = 2'd1,
    RD_SRC_MEM = 2'd2
  } rd_src_e;

  typedef enum logic [1:0] {
    MEM_OP_NOP   = 2'd0,
    MEM_OP_LOAD  = 2'd1,
    MEM_OP_STORE = 2'd2,
    MEM_OP_AMO   = 2'd3
  } mem_op_e;

  typedef enum logic [3:0] {
    AMO_OP_SWAP = 4'd0,
    AMO_OP_ADD  = 4'd1,
    AMO_OP_AND  = 4'd2,
    AMO_OP_OR   = 4'd3,
    AMO_OP_XOR  = 4'd4,
    AMO_OP_MIN  = 4'd5,
    AMO_OP_MAX  = 4'd6,
    AMO_OP_MINU = 4'd7,
    AMO_OP_MAXU = 4'd8
  } amo_alu_op_e;

  typedef enum logic {
    WB_AMO_IDLE = 1'b0,
    WB_AMO_SENT = 1'b1
  } wb_amo_state_e;

  typedef struct packed {
    rd_src_e               rd_src;
    logic                  rd_we;
    logic [RIDX_W-1:0]     rd_idx;
    word_t                 alu_result;
    word_t                 csr_old_val;
    word_t                 mem_rdata;
    word_t                 rs2_val;
    mem_op_e               mem_op;
    amo_alu_op_e           amo_alu_op;
    logic                  csr_expl_wen;
    logic [CSR_IDX_W-1:0]  csr_idx;
    word_t                 csr_new_val;
  } m2_to_w_s;

endpackage

// File: rtl/letc_core_forwarder_if.sv
// Forwarding source bundle published by a pipeline stage to the hazard/bypass logic.
interface letc_core_forwarder_if;
  import letc_core_pkg::*;

  logic              instr_produces_rd;
  logic [RIDX_W-1:0] rd_idx;
  logic              rd_val_avail;
  word_t             rd_val;

  modport stage  (output instr_produces_rd, rd_idx, rd_val_avail, rd_val);
  modport hazard (input  instr_produces_rd, rd_idx, rd_val_avail, rd_val);
endinterface

// File: rtl/letc_core_amo_alu.sv
// Combinational AMO read-modify-write ALU: a is the old memory value, b is rs2.
module letc_core_amo_alu
  import letc_core_pkg::*;
(
  input  amo_alu_op_e op,
  input  word_t       a,
  input  word_t       b,
  output word_t       result
);

  always_comb begin
    result = BAD_WORD;
    case (op)
      AMO_OP_SWAP: result = b;
      AMO_OP_ADD:  result = a + b;
      AMO_OP_AND:  result = a & b;
      AMO_OP_OR:   result = a | b;
      AMO_OP_XOR:  result = a ^ b;
      AMO_OP_MIN:  result = ($signed(a) < $signed(b)) ? a : b;
      AMO_OP_MAX:  result = ($signed(a) < $signed(b)) ? b : a;
      AMO_OP_MINU: result = (a < b) ? a : b;
      AMO_OP_MAXU: result = (a < b) ? b : a;
      default:     result = BAD_WORD;
    endcase
  end

endmodule

// File: rtl/letc_core_stage_writeback.sv
// LETC writeback stage: retires one instruction per cycle, commits rd/CSR writes,
// issues AMO store-backs and counts retired instructions.
module letc_core_stage_writeback
  import letc_core_pkg::*;
#(
  parameter int unsigned INSTRET_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  w_ready,
  input  logic                  w_flush,
  input  logic                  w_stall,
  input  logic                  m2_to_w_valid,
  input  m2_to_w_s              m2_to_w,
  output logic                  rf_we,
  output logic [RIDX_W-1:0]     rf_widx,
  output word_t                 rf_wdata,
  output logic                  csr_we,
  output logic [CSR_IDX_W-1:0]  csr_widx,
  output word_t                 csr_wdata,
  output logic                  amo_st_valid,
  input  logic                  amo_st_ready,
  output word_t                 amo_st_addr,
  output word_t                 amo_st_data,
  letc_core_forwarder_if.stage  w_forwarder,
  output logic                  retire,
  output logic [INSTRET_W-1:0]  instret
);

  m2_to_w_s               ff_in;
  logic                   ff_in_valid;
  wb_amo_state_e          state;
  wb_amo_state_e          state_next;
  logic                   is_amo;
  logic [INSTRET_W-1:0]   instret_q;

  // Input register; contents are don't-care while ff_in_valid is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff_in_valid <= 1'b0;
    end else if (!w_stall) begin
      ff_in_valid <= m2_to_w_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!w_stall) begin
      ff_in <= m2_to_w;
    end
  end

  assign is_amo = ff_in_valid && (ff_in.mem_op == MEM_OP_AMO);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= WB_AMO_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // SENT remembers an accepted store-back so a stalled AMO never issues twice
  always_comb begin
    state_next   = state;
    amo_st_valid = 1'b0;
    case (state)
      WB_AMO_IDLE: begin
        amo_st_valid = is_amo && !w_flush;
        if (amo_st_valid && amo_st_ready && w_stall) begin
          state_next = WB_AMO_SENT;
        end
      end
      WB_AMO_SENT: begin
        if (!w_stall || w_flush) begin
          state_next = WB_AMO_IDLE;
        end
      end
      default: state_next = WB_AMO_IDLE;
    endcase
  end

  assign w_ready = !((state == WB_AMO_IDLE) && is_amo && !amo_st_ready);

  assign retire = ff_in_valid && !w_flush && !w_stall;

  always_comb begin
    rf_wdata = BAD_WORD;
    case (ff_in.rd_src)
      RD_SRC_ALU: rf_wdata = ff_in.alu_result;
      RD_SRC_CSR: rf_wdata = ff_in.csr_old_val;
      RD_SRC_MEM: rf_wdata = ff_in.mem_rdata;
      default:    rf_wdata = BAD_WORD;
    endcase
  end

  assign rf_we     = retire && ff_in.rd_we && (ff_in.rd_idx != RIDX_W'(0));
  assign rf_widx   = ff_in.rd_idx;

  assign csr_we    = retire && ff_in.csr_expl_wen;
  assign csr_widx  = ff_in.csr_idx;
  assign csr_wdata = ff_in.csr_new_val;

  assign amo_st_addr = ff_in.alu_result;

  letc_core_amo_alu u_amo_alu (
    .op     (ff_in.amo_alu_op),
    .a      (ff_in.mem_rdata),
    .b      (ff_in.rs2_val),
    .result (amo_st_data)
  );

  assign w_forwarder.instr_produces_rd = ff_in_valid && ff_in.rd_we;
  assign w_forwarder.rd_idx            = ff_in.rd_idx;
  assign w_forwarder.rd_val_avail      = 1'b1;
  assign w_forwarder.rd_val            = rf_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  assign instret = instret_q;

  // An accepted store-back cannot be recalled, so flushing in SENT is an ordering bug
  a_no_flush_in_sent: assert property (@(posedge clk) disable iff (!rst_n)
    !((state == WB_AMO_SENT) && w_flush));

endmodule

// File: doc/letc_core_stage_writeback.md
Name: letc_core_stage_writeback

Overview:
Final LETC core pipeline stage; consumes the memory2-to-writeback bundle and retires one instruction per cycle. It selects and writes rd to the register file and commits explicit CSR writes. It also executes AMO read-modify-write: it computes the AMO result from load data and rs2, then issues the store-back to the DMSS with a valid/ready handshake. It forwards its rd value to earlier stages and keeps a 64-bit retired-instruction counter.

Parameters:
INSTRET_W, 64, width of the retired-instruction counter.

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
w_ready  output  1  low while an AMO store-back is pending and not yet accepted
w_flush  input  1  kill the instruction currently held in the stage
w_stall  input  1  hold the input register; the held instruction must not retire
m2_to_w_valid  input  1  upstream valid
m2_to_w  input  m2_to_w_s  upstream bundle; the pkg adds an amo_alu_op field
rf_we  output  1  register-file write enable
rf_widx  output  5  register-file write index
rf_wdata  output  32  register-file write data
csr_we  output  1  explicit CSR write enable
csr_widx  output  12  CSR index
csr_wdata  output  32  CSR write data
amo_st_valid  output  1  AMO store-back request
amo_st_ready  input  1  DMSS accepts the store-back
amo_st_addr  output  32  store address (alu_result)
amo_st_data  output  32  AMO result
w_forwarder  interface  letc_core_forwarder_if.stage  rd forwarding source
retire  output  1  one-cycle pulse per retired instruction
instret  output  INSTRET_W  retired-instruction count

Behaviour:
- Reset behaviour: rst_n is synchronous and active-low on clk. Reset clears ff_in_valid, the FSM (to IDLE) and instret. All enables and valids (rf_we, csr_we, amo_st_valid, retire) are 0 out of reset.
- Input register: ff_in is loaded from m2_to_w, and ff_in_valid from m2_to_w_valid, on any cycle with !w_stall. ff_in is not reset.
- is_amo = ff_in_valid && ff_in.mem_op==MEM_OP_AMO.
- FSM, two states:
  - IDLE: amo_st_valid = is_amo && !w_flush. If amo_st_valid && amo_st_ready && w_stall, go to SENT.
  - SENT: amo_st_valid=0. Return to IDLE on any cycle where !w_stall (instruction retires or is replaced), or on w_flush.
  - Net effect: exactly one store-back per AMO, even under an extended stall.
- w_ready = !(state==IDLE && is_amo && !amo_st_ready). It is combinational; the hazard unit derives w_stall from it.
- Retire condition: retire = ff_in_valid && !w_flush && !w_stall. This is zero-latency from the ff_in contents.
- rf_we = retire && ff_in.rd_we && rd_idx!=0. rf_widx = ff_in.rd_idx.
- rf_wdata select:
  - RD_SRC_ALU: alu_result.
  - RD_SRC_CSR: csr_old_val.
  - RD_SRC_MEM: mem_rdata; for an AMO this is the old memory value.
  - Any other source: 32'hDEADBEEF.
- CSR commit: csr_we = retire && csr_expl_wen. csr_widx = csr_idx. csr_wdata = csr_new_val.
- AMO ALU, with a = mem_rdata and b = rs2_val:
  - SWAP returns b. ADD, AND, OR, XOR are the plain 32-bit operations; ADD wraps mod 2^32.
  - MIN and MAX use signed compare; MINU and MAXU use unsigned compare.
  - Any other op returns 32'hDEADBEEF.
  - amo_st_addr = alu_result.
- Forwarder: instr_produces_rd = ff_in_valid && rd_we; rd_idx = ff_in.rd_idx; rd_val_avail = 1; rd_val = rf_wdata mux.
- instret increments by 1 on retire and wraps from all-ones to 0.
- Flush and stall together: flush dominates; there is no retire and no store issue.
- A flush asserted in SENT does not recall the accepted store; ordering makes this illegal, and an assertion flags it in simulation.

Decomposition:
- letc_core_pkg: amo_alu_op_e (SWAP, ADD, AND, OR, XOR, MIN, MAX, MINU, MAXU), the amo_alu_op field in m2_to_w_s, and the wb_amo_state_e enum.
- Sub-module: letc_core_amo_alu, combinational (op, a, b -> result); it is reused by any future cache-side AMO unit.

Test Plan:
- ALU load-immediate to x5=0x1234, no stall -> rf_we=1, rf_widx=5, rf_wdata=0x00001234 in the same cycle; retire=1, instret 0->1.
- rd_we=1 with rd_idx=0 -> rf_we=0, retire=1.
- AMOADD with mem_rdata=0x7FFFFFFF, rs2=1, amo_st_ready low for 3 cycles:
  - w_ready=0 and amo_st_valid=1 for 3 cycles.
  - On the 4th cycle ready=1: amo_st_data=0x80000000; rf_wdata=0x7FFFFFFF written once; exactly one handshake.
- AMOMIN with a=0xFFFFFFFF, b=1 -> store 0xFFFFFFFF. AMOMINU with the same operands -> store 0x00000001.
- AMO accepted while external w_stall is held 2 more cycles -> FSM goes to SENT, amo_st_valid=0 in those cycles, single retire when the stall drops.
- w_flush with valid CSR write (idx 0x340, val 0xA5) -> csr_we=0, rf_we=0, retire=0. The unflushed repeat commits 0xA5 to 0x340.
- instret preloaded via force to 2^64-1, then one retire -> instret=0.
